dstack_spill_ctrl: RTL and testbench
====================================

DSTACK_SPILL_CTRL -- requirements
Module: dstack_spill_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- WORD_WIDTH, 32, data and address word width.
- DEPTH, 16, on-chip data stack entries.
- HIGH_WATER, 12, spill threshold.
- LOW_WATER, 4, fill threshold.
REQ-002 Parameter constraints: 2 < LOW_WATER < HIGH_WATER < DEPTH.
REQ-003 Clock and reset: single clock; reset is synchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- movement, in, 2, core stack movement: 00 hold, 01 push1, 10 pop1, 11 pop2.
- halt, in, 1, core halted.
- bottom_value, in, WORD_WIDTH, oldest on-chip entry.
- stack_base, in, WORD_WIDTH, spill-area base (word address).
- depth, out, $clog2(DEPTH+1), on-chip occupancy.
- spilled, out, WORD_WIDTH, words held in memory.
- stall, out, 1, core must not commit movement this cycle.
- spill_drop, out, 1, 1-cycle pulse: remove bottom entry.
- fill_valid, out, 1, 1-cycle pulse: insert fill_data below bottom.
- fill_data, out, WORD_WIDTH, filled word.
- underflow, out, 1, sticky error flag.
- mem_req, out, 1, memory request.
- mem_we, out, 1, write (1) / read (0).
- mem_addr, out, WORD_WIDTH, memory address.
- mem_wdata, out, WORD_WIDTH, write data.
- mem_ack, in, 1, transaction complete.
- mem_rdata, in, WORD_WIDTH, read data, valid with mem_ack.

Function
REQ-005 Effective movement: halt=1 forces hold; stall=0 during halt.
REQ-006 Per-cycle quantities:
- push = 1 for 01, else 0.
- pop = 1 for 10, 2 for 11, else 0.
- sc = spill commit (SPILL state and mem_ack).
- fc = fill commit (FILL state and mem_ack).
REQ-007 Underflow: depth < pop and spilled = 0 -> set underflow; movement dropped; stall=0; depth unchanged by movement.
REQ-008 stall=1 when any of the following holds:
- push=1 and depth + 1 + fc > DEPTH;
- depth < pop and spilled > 0;
- state SPILL and depth - pop < 2.
REQ-009 Non-stalled, non-underflow movement commits the same cycle.
REQ-010 Next depth = depth + committed push - committed pop + fc - sc.
REQ-011 Next spilled = spilled + sc - fc.
REQ-012 FSM states IDLE, SPILL, FILL; transitions registered.
REQ-013 IDLE -> SPILL when depth > HIGH_WATER.
REQ-014 IDLE -> FILL when depth < LOW_WATER and spilled > 0.
REQ-015 IDLE decision priority: SPILL over FILL.
REQ-016 Entering SPILL latches:
- mem_addr = stack_base + spilled (mod 2^WORD_WIDTH);
- mem_wdata = bottom_value;
- mem_we = 1.
REQ-017 Entering FILL latches mem_addr = stack_base + spilled - 1 and mem_we = 0.
REQ-018 mem_req=1 exactly while in SPILL/FILL; it rises the cycle after the IDLE decision.
REQ-019 mem_addr, mem_we and mem_wdata are held stable while mem_req=1.
REQ-020 mem_ack is sampled only while mem_req=1; ack in IDLE is ignored.
REQ-021 mem_ack in SPILL: spill_drop=1 that cycle (combinational); next state IDLE.
REQ-022 mem_ack in FILL: fill_valid=1 and fill_data=mem_rdata that cycle (combinational); next state IDLE.
REQ-023 At least one IDLE cycle separates consecutive transactions.
REQ-024 Zero-wait ack (ack in first req cycle) is legal.
REQ-025 Thresholds are re-evaluated in IDLE using the current depth; no queued requests.
REQ-026 fill_data = 0 when fill_valid = 0.

Reset
REQ-027 On reset:
- state IDLE;
- depth = 0, spilled = 0, underflow = 0;
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
- spill_drop = 0, fill_valid = 0, stall = 0.
REQ-028 Reset mid-transaction abandons it: mem_req=0 next cycle; a later mem_ack is ignored.
REQ-029 Reset overrides halt and movement.
REQ-030 Only reset clears underflow.

Verification
REQ-031 Bench scenarios, with DEPTH=16, HIGH_WATER=12, LOW_WATER=4, stack_base=0x1000:
- Reset, idle 5 cycles -> depth=0, spilled=0, mem_req=0, stall=0, underflow=0.
- 13 pushes; bottom_value=0xA5A5A5A5; ack 3 cycles after req -> mem_req=1, mem_we=1, mem_addr=0x1000, mem_wdata=0xA5A5A5A5; ack-cycle spill_drop=1; then depth=12, spilled=1.
- Push to depth 16 with mem_ack held 0; push again -> stall=1, depth stays 16; after ack, push accepted.
- Preload depth=3, spilled=2; ack with mem_rdata=0xDEADBEEF -> mem_we=0, mem_addr=0x1001, fill_valid=1, fill_data=0xDEADBEEF; then depth=4, spilled=1.
- depth=0, spilled=0, movement=10 -> underflow=1, stall=0, depth=0; underflow persists until reset.
- Reset asserted in SPILL with req pending -> mem_req=0 next cycle; later mem_ack leaves spilled=0, spill_drop=0.

Source files
------------

// File: rtl/dstack_spill_ctrl.sv
// Data-stack spill/fill controller: keeps on-chip occupancy between water marks via single-word memory transfers.
// Latency: threshold decision registered in IDLE, mem_req rises next cycle; commit is combinational on mem_ack.
// Backpressure: stall holds the core's movement while it would overflow, underflow into memory, or starve a pending spill.
module dstack_spill_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int HIGH_WATER = 12,
  parameter int LOW_WATER  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   movement,
  input  logic                         halt,
  input  logic [WORD_WIDTH-1:0]        bottom_value,
  input  logic [WORD_WIDTH-1:0]        stack_base,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [WORD_WIDTH-1:0]        spilled,
  output logic                         stall,
  output logic                         spill_drop,
  output logic                         fill_valid,
  output logic [WORD_WIDTH-1:0]        fill_data,
  output logic                         underflow,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_WIDTH-1:0]        mem_addr,
  output logic [WORD_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_ack,
  input  logic [WORD_WIDTH-1:0]        mem_rdata
);

  localparam int DW = $clog2(DEPTH + 1);
  // Two guard bits so depth+push+fill and depth-pop comparisons never wrap.
  localparam int AW = DW + 2;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t          state, state_n;
  logic            push;
  logic [1:0]      pop;
  logic            sc, fc, uf;
  logic            stall_raw, commit;
  logic            load_spill, load_fill;
  logic [AW-1:0]   depth_x, pop_x, depth_n_x;

  // Movement decode, commit/stall decisions and next occupancy.
  always_comb begin
    push = 1'b0;
    pop  = 2'd0;
    if (!halt) begin
      case (movement)
        2'b01:   push = 1'b1;
        2'b10:   pop  = 2'd1;
        2'b11:   pop  = 2'd2;
        default: ;
      endcase
    end
    depth_x = AW'(depth);
    pop_x   = AW'(pop);
    sc      = (state == SPILL) && mem_ack;
    fc      = (state == FILL) && mem_ack;
    // Popping past the bottom with nothing in memory is a core bug, not a wait.
    uf      = (depth_x < pop_x) && (spilled == '0);
    // A pending spill must keep at least two words on chip: the one being
    // written out still sits at the bottom until the ack drops it.
    stall_raw = (push && ((depth_x + AW'(1) + AW'(fc)) > AW'(DEPTH))) ||
                ((depth_x < pop_x) && (spilled != '0)) ||
                ((state == SPILL) && (depth_x < (pop_x + AW'(2))));
    stall   = !reset && !halt && !uf && stall_raw;
    commit  = !stall && !uf;
    depth_n_x = depth_x + AW'(fc) - AW'(sc);
    if (commit) depth_n_x = depth_n_x + AW'(push) - pop_x;
    spill_drop = !reset && sc;
    fill_valid = !reset && fc;
    fill_data  = fill_valid ? mem_rdata : '0;
  end

  // Transfer FSM: pick spill over fill from current occupancy, wait for ack.
  always_comb begin
    state_n    = state;
    load_spill = 1'b0;
    load_fill  = 1'b0;
    mem_req    = (state != IDLE);
    case (state)
      IDLE: begin
        if (depth_x > AW'(HIGH_WATER)) begin
          state_n    = SPILL;
          load_spill = 1'b1;
        end else if ((depth_x < AW'(LOW_WATER)) && (spilled != '0)) begin
          state_n   = FILL;
          load_fill = 1'b1;
        end
      end
      SPILL, FILL: begin
        if (mem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Occupancy counters, sticky error, and the request fields latched on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth     <= '0;
      spilled   <= '0;
      underflow <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      depth     <= DW'(depth_n_x);
      spilled   <= spilled + WORD_WIDTH'(sc) - WORD_WIDTH'(fc);
      underflow <= underflow | uf;
      if (load_spill) begin
        mem_addr  <= stack_base + spilled;
        mem_wdata <= bottom_value;
        mem_we    <= 1'b1;
      end else if (load_fill) begin
        mem_addr  <= stack_base + spilled - WORD_WIDTH'(1);
        mem_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dstack_spill_ctrl.sv
// Bench for dstack_spill_ctrl: directed scenarios plus randomized traffic.
// Every cycle the outputs are compared against a counter-level stack model.
// Directed scenarios add hand-computed literal expectations.
module tb_dstack_spill_ctrl;

  localparam int WW = 32;
  localparam int DP = 16;
  localparam int HW = 12;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        movement = 2'b00;
  logic              halt = 1'b0;
  logic [WW-1:0]     bottom_value = '0;
  logic [WW-1:0]     stack_base = 32'h0000_1000;
  logic [4:0]        depth;
  logic [WW-1:0]     spilled;
  logic              stall, spill_drop, fill_valid, underflow;
  logic [WW-1:0]     fill_data;
  logic              mem_req, mem_we;
  logic [WW-1:0]     mem_addr, mem_wdata;
  logic              mem_ack = 1'b0;
  logic [WW-1:0]     mem_rdata = '0;

  int total = 0;
  int bad = 0;

  // Model: occupancy counters plus the one outstanding transfer (0 none, 1 write, 2 read).
  int            m_depth = 0, m_spilled = 0, m_busy = 0;
  bit            m_uf = 1'b0;
  bit            m_we = 1'b0;
  logic [WW-1:0] m_addr = '0, m_wdata = '0;

  // Output snapshot taken just before each rising edge.
  logic          s_stall, s_spill_drop, s_fill_valid, s_mem_req, s_mem_we;
  logic [WW-1:0] s_fill_data, s_mem_addr, s_mem_wdata;

  always #5 clk = ~clk;

  dstack_spill_ctrl #(.WORD_WIDTH(WW), .DEPTH(DP), .HIGH_WATER(HW), .LOW_WATER(LW)) dut (
    .clk(clk), .reset(reset), .movement(movement), .halt(halt),
    .bottom_value(bottom_value), .stack_base(stack_base),
    .depth(depth), .spilled(spilled), .stall(stall), .spill_drop(spill_drop),
    .fill_valid(fill_valid), .fill_data(fill_data), .underflow(underflow),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk_eq(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic step(input logic [1:0] mv, input logic h, input logic a,
                      input logic [WW-1:0] rd, input logic r, input bit chk);
    int  e_push, e_pop, od, os;
    bit  e_sc, e_fc, e_uf, e_stall;
    movement = mv; halt = h; mem_ack = a; mem_rdata = rd; reset = r;
    #1;
    s_stall = stall; s_spill_drop = spill_drop; s_fill_valid = fill_valid;
    s_fill_data = fill_data; s_mem_req = mem_req; s_mem_we = mem_we;
    s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;

    e_push = (!h && mv == 2'b01) ? 1 : 0;
    e_pop  = h ? 0 : (mv == 2'b10) ? 1 : (mv == 2'b11) ? 2 : 0;
    e_sc   = !r && (m_busy == 1) && a;
    e_fc   = !r && (m_busy == 2) && a;
    e_uf   = !r && (m_depth < e_pop) && (m_spilled == 0);
    e_stall = !r && !h && !e_uf &&
              ((e_push == 1 && m_depth + 1 + int'(e_fc) > DP) ||
               (m_depth < e_pop && m_spilled > 0) ||
               (m_busy == 1 && m_depth - e_pop < 2));
    if (chk) begin
      chk_eq("depth", 32'(depth), 32'(m_depth));
      chk_eq("spilled", spilled, 32'(m_spilled));
      chk_eq("underflow", 32'(underflow), 32'(m_uf));
      chk_eq("stall", 32'(stall), 32'(e_stall));
      chk_eq("spill_drop", 32'(spill_drop), 32'(e_sc));
      chk_eq("fill_valid", 32'(fill_valid), 32'(e_fc));
      chk_eq("fill_data", fill_data, e_fc ? rd : 32'h0);
      chk_eq("mem_req", 32'(mem_req), 32'(m_busy != 0));
      chk_eq("mem_we", 32'(mem_we), 32'(m_we));
      chk_eq("mem_addr", mem_addr, m_addr);
      chk_eq("mem_wdata", mem_wdata, m_wdata);
    end

    if (r) begin
      m_depth = 0; m_spilled = 0; m_busy = 0; m_uf = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
    end else begin
      od = m_depth; os = m_spilled;
      if (!e_stall && !e_uf) m_depth = m_depth + e_push - e_pop;
      m_depth   = m_depth + int'(e_fc) - int'(e_sc);
      m_spilled = m_spilled + int'(e_sc) - int'(e_fc);
      if (e_uf) m_uf = 1'b1;
      if (m_busy == 0) begin
        if (od > HW) begin
          m_busy = 1; m_we = 1'b1;
          m_addr = stack_base + 32'(os); m_wdata = bottom_value;
        end else if (od < LW && os > 0) begin
          m_busy = 2; m_we = 1'b0;
          m_addr = stack_base + 32'(os) - 32'd1;
        end
      end else if (a) begin
        m_busy = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic pushes(input int n);
    for (int i = 0; i < n; i++) step(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Hold until a request is seen in the snapshot; an expired budget is a failure.
  task automatic wait_req(input string name);
    s_mem_req = 1'b0;
    for (int i = 0; i < 8 && s_mem_req !== 1'b1; i++) hold(1);
    chk_eq(name, 32'(s_mem_req), 32'd1);
  endtask

  initial begin
    bottom_value = 32'hA5A5_A5A5;
    @(negedge clk);
    step(2'b00, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Reset then idle.
    hold(5);
    chk_eq("rst_depth", 32'(depth), 32'd0);
    chk_eq("rst_spilled", spilled, 32'd0);
    chk_eq("rst_req", 32'(mem_req), 32'd0);
    chk_eq("rst_stall", 32'(stall), 32'd0);
    chk_eq("rst_uf", 32'(underflow), 32'd0);

    // Thirteen pushes trigger a spill; ack three cycles after the request.
    pushes(13);
    wait_req("spill_req");
    hold(2);
    step(2'b00, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    chk_eq("spill_we", 32'(s_mem_we), 32'd1);
    chk_eq("spill_addr", s_mem_addr, 32'h0000_1000);
    chk_eq("spill_wdata", s_mem_wdata, 32'hA5A5_A5A5);
    chk_eq("spill_drop", 32'(s_spill_drop), 32'd1);
    chk_eq("spill_depth", 32'(depth), 32'd12);
    chk_eq("spill_cnt", spilled, 32'd1);

    // Fill to the top with the spill unacknowledged, then push once more.
    for (int i = 0; i < 8 && depth != 5'd16; i++) pushes(1);
    chk_eq("full_depth", 32'(depth), 32'd16);
    step(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_eq("full_stall", 32'(s_stall), 32'd1);
    chk_eq("full_hold", 32'(depth), 32'd16);
    step(2'b01, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_eq("after_ack_stall", 32'(s_stall), 32'd0);
    chk_eq("after_ack_depth", 32'(depth), 32'd16);

    // Build depth=3, spilled=2, then fill from address base+1.
    step(2'b00, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    pushes(13);
    wait_req("pre_req1");
    step(2'b00, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    pushes(1);
    wait_req("pre_req2");
    step(2'b00, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_eq("pre_depth", 32'(depth), 32'd3);
    chk_eq("pre_spilled", spilled, 32'd2);
    wait_req("fill_req");
    chk_eq("fill_we", 32'(s_mem_we), 32'd0);
    chk_eq("fill_addr", s_mem_addr, 32'h0000_1001);
    step(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk_eq("fill_valid", 32'(s_fill_valid), 32'd1);
    chk_eq("fill_data", s_fill_data, 32'hDEAD_BEEF);
    chk_eq("fill_depth", 32'(depth), 32'd4);
    chk_eq("fill_spilled", spilled, 32'd1);

    // Underflow on an empty stack is sticky until reset.
    step(2'b00, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_eq("uf_stall", 32'(s_stall), 32'd0);
    chk_eq("uf_set", 32'(underflow), 32'd1);
    chk_eq("uf_depth", 32'(depth), 32'd0);
    pushes(3);
    hold(2);
    chk_eq("uf_sticky", 32'(underflow), 32'd1);
    step(2'b00, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk_eq("uf_clear", 32'(underflow), 32'd0);

    // Reset during a pending spill abandons it; a late ack is ignored.
    pushes(13);
    wait_req("abort_req");
    step(2'b00, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk_eq("abort_req_low", 32'(mem_req), 32'd0);
    step(2'b00, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    chk_eq("abort_drop", 32'(s_spill_drop), 32'd0);
    chk_eq("abort_spilled", spilled, 32'd0);

    // Randomized traffic, push-biased so both water marks get crossed.
    for (int i = 0; i < 4000; i++) begin
      int rm;
      logic [1:0] mv;
      rm = $urandom_range(0, 99);
      mv = (rm < 40) ? 2'b01 : (rm < 65) ? 2'b10 : (rm < 75) ? 2'b11 : 2'b00;
      if ((i / 500) % 2 == 1 && mv == 2'b01) mv = 2'b10;
      bottom_value = $urandom;
      stack_base   = (i % 700 == 350) ? 32'hFFFF_FFFE : 32'h0000_1000;
      step(mv, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 35),
           $urandom, ($urandom_range(0, 199) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
